bk_add_scheduler: RTL

//  Shares one 32-bit Brent-Kung adder among NREQ requesters. Each requester issues multi-word
//  (multi-precision) add operations as a little-endian word stream; carry-out of each word chains

---
 rtl/bk_pkg.sv | 23 ++
 rtl/bk_rr_arbiter.sv | 37 +++
 rtl/top_Brent_Kung.sv | 49 ++++
 rtl/bk_add_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared definitions for the multi-precision add scheduler.
//   WORD_W       : datapath word width of the shared adder
//   bk_state_e   : grant FSM states
//   rr_next_idx  : round-robin successor of a requester index
package bk_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bk_state_e;

  // Index of the requester that follows idx, wrapping at nreq.
  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned nreq);
    if ((idx + 32'd1) >= nreq) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/bk_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i      in  NREQ  request vector
//   ptr_i      in  IDW   highest-priority requester index
//   gnt_oh_o   out NREQ  one-hot grant (zero when no request)
//   gnt_idx_o  out IDW   index of the granted requester (0 when no request)
module bk_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic found_s;
  int   cand_s;

  // Scan from the pointer, wrapping once, and grant the first active request.
  always_comb begin
    found_s   = 1'b0;
    cand_s    = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = (int'(ptr_i) + i) % NREQ;
      if (!found_s && req_i[cand_s]) begin
        found_s          = 1'b1;
        gnt_oh_o[cand_s] = 1'b1;
        gnt_idx_o        = IDW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/top_Brent_Kung.sv
// 32-bit Brent-Kung parallel-prefix adder, purely combinational.
//   a, b  in  32  operands
//   cin   in  1   carry-in
//   sum   out 33  {carry-out, sum word}
module top_Brent_Kung (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [32:0] sum
);

  // Carry-in is folded into bit 0's generate so the prefix tree yields
  // carry-into-bit-(i+1) directly in gg[i]. Up-sweep builds power-of-two
  // spans, down-sweep fills the remaining positions.
  function automatic logic [32:0] bk_sum(input logic [31:0] a_i, input logic [31:0] b_i,
                                         input logic c_i);
    logic [31:0] g_v;
    logic [31:0] p_v;
    logic [31:0] gg;
    logic [31:0] pp;
    logic [32:0] res;
    g_v   = a_i & b_i;
    p_v   = a_i ^ b_i;
    gg    = g_v;
    pp    = p_v;
    gg[0] = g_v[0] | (p_v[0] & c_i);
    for (int l = 0; l < 5; l++) begin
      for (int i = (32'sd2 << l) - 32'sd1; i < 32; i += (32'sd2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (32'sd1 << l)]);
        pp[i] = pp[i] & pp[i - (32'sd1 << l)];
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = (32'sd3 << l) - 32'sd1; i < 32; i += (32'sd2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (32'sd1 << l)]);
        pp[i] = pp[i] & pp[i - (32'sd1 << l)];
      end
    end
    res[0] = p_v[0] ^ c_i;
    for (int i = 1; i < 32; i++) begin
      res[i] = p_v[i] ^ gg[i - 1];
    end
    res[32] = gg[31];
    return res;
  endfunction

  assign sum = bk_sum(a, b, cin);

endmodule

// File: rtl/bk_add_scheduler.sv
// Shares one Brent-Kung adder among NREQ requesters issuing multi-word adds.
// A requester is granted for a whole operation (round robin), its words pass
// through an operand register and a result register, and the carry-out of
// each word feeds the next word of the same operation.
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester word handshake (ready one-hot or zero)
//   req_a/req_b             operand words, requester r at [32r+31:32r]
//   req_cin                 carry-in, used on the first word only
//   req_last                final word of the operation
//   res_valid/res_ready     result word handshake
//   res_sum/res_cout        sum word and its carry-out
//   res_last/res_id         final-word marker and owning requester
//   busy                    FSM active or a pipeline stage occupied
//   ops_done                completed operations (wrapping)
module bk_add_scheduler
  import bk_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORD_W-1:0]   req_a,
  input  logic [NREQ*WORD_W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_cin,
  input  logic [NREQ-1:0]          req_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WORD_W-1:0]        res_sum,
  output logic                     res_cout,
  output logic                     res_last,
  output logic [IDW-1:0]           res_id,
  output logic                     busy,
  output logic [CNTW-1:0]          ops_done
);

  bk_state_e         state_q, state_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic              first_q, first_d;
  logic              carry_q, carry_d;

  logic              op_vld_q, op_vld_d;
  logic [WORD_W-1:0] op_a_q, op_a_d;
  logic [WORD_W-1:0] op_b_q, op_b_d;
  logic              op_cin_q, op_cin_d;
  logic              op_last_q, op_last_d;
  logic [IDW-1:0]    op_id_q, op_id_d;

  logic              res_vld_q, res_vld_d;
  logic [WORD_W-1:0] res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;
  logic              res_last_q, res_last_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic [CNTW-1:0]   ops_done_q, ops_done_d;
  logic              busy_q, busy_d;

  logic              res_fire_s;
  logic              op_move_s;
  logic              op_free_s;
  logic              accept_s;
  logic [NREQ-1:0]   arb_oh_s;
  logic [IDW-1:0]    arb_idx_s;
  logic              arb_any_s;
  logic              sel_valid_s;
  logic              sel_cin_s;
  logic              sel_last_s;
  logic [WORD_W-1:0] sel_a_s;
  logic [WORD_W-1:0] sel_b_s;
  logic [WORD_W:0]   add_sum_s;

  bk_rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_q),
    .gnt_oh_o (arb_oh_s),
    .gnt_idx_o(arb_idx_s)
  );

  assign arb_any_s = |arb_oh_s;

  top_Brent_Kung u_add (
    .a  (op_a_q),
    .b  (op_b_q),
    .cin(op_cin_q),
    .sum(add_sum_s)
  );

  // Stage movement: the result stage frees on a handshake, the operand
  // stage advances whenever the result stage is (or is becoming) free.
  always_comb begin
    res_fire_s = res_vld_q & res_ready;
    op_move_s  = op_vld_q & (~res_vld_q | res_ready);
    op_free_s  = ~op_vld_q | op_move_s;
  end

  // Pick out the granted requester's word fields.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_cin_s   = 1'b0;
    sel_last_s  = 1'b0;
    sel_a_s     = '0;
    sel_b_s     = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_q == IDW'(r)) begin
        sel_valid_s = req_valid[r];
        sel_cin_s   = req_cin[r];
        sel_last_s  = req_last[r];
        sel_a_s     = req_a[r*WORD_W +: WORD_W];
        sel_b_s     = req_b[r*WORD_W +: WORD_W];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Grant FSM: IDLE arbitrates (one bubble per operation), BUSY streams the
  // granted requester's words until its last word is accepted.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    first_d   = first_q;
    req_ready = '0;
    accept_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          gnt_d   = arb_idx_s;
          first_d = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        for (int r = 0; r < NREQ; r++) begin
          if (gnt_q == IDW'(r)) begin
            req_ready[r] = op_free_s;
          end else begin
            req_ready[r] = 1'b0;
          end
        end
        accept_s = sel_valid_s & op_free_s;
        if (accept_s) begin
          first_d = 1'b0;
          if (sel_last_s) begin
            rr_d    = IDW'(rr_next_idx(32'(gnt_q), 32'(NREQ)));
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand stage. When the previous word is leaving this very edge its carry
  // is still only on the adder output, so it is taken from there instead of
  // the carry register.
  always_comb begin
    op_vld_d  = op_vld_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_cin_d  = op_cin_q;
    op_last_d = op_last_q;
    op_id_d   = op_id_q;
    if (accept_s) begin
      op_vld_d  = 1'b1;
      op_a_d    = sel_a_s;
      op_b_d    = sel_b_s;
      op_last_d = sel_last_s;
      op_id_d   = gnt_q;
      if (first_q) begin
        op_cin_d = sel_cin_s;
      end else if (op_move_s) begin
        op_cin_d = add_sum_s[WORD_W];
      end else begin
        op_cin_d = carry_q;
      end
    end else if (op_move_s) begin
      op_vld_d = 1'b0;
    end else begin
      op_vld_d = op_vld_q;
    end
  end

  // Result stage, chain carry and completed-operation counter.
  always_comb begin
    res_vld_d  = res_vld_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_last_d = res_last_q;
    res_id_d   = res_id_q;
    carry_d    = carry_q;
    ops_done_d = ops_done_q;
    if (op_move_s) begin
      res_vld_d  = 1'b1;
      res_sum_d  = add_sum_s[WORD_W-1:0];
      res_cout_d = add_sum_s[WORD_W];
      res_last_d = op_last_q;
      res_id_d   = op_id_q;
      carry_d    = add_sum_s[WORD_W];
    end else if (res_fire_s) begin
      res_vld_d = 1'b0;
    end else begin
      res_vld_d = res_vld_q;
    end
    if (res_fire_s && res_last_q) begin
      ops_done_d = ops_done_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      ops_done_d = ops_done_q;
    end
    busy_d = (state_d != ST_IDLE) | op_vld_d | res_vld_d;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      first_q    <= 1'b0;
      carry_q    <= 1'b0;
      op_vld_q   <= 1'b0;
      res_vld_q  <= 1'b0;
      ops_done_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      first_q    <= first_d;
      carry_q    <= carry_d;
      op_vld_q   <= op_vld_d;
      res_vld_q  <= res_vld_d;
      ops_done_q <= ops_done_d;
      busy_q     <= busy_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      op_last_q  <= 1'b0;
      op_id_q    <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_last_q <= 1'b0;
      res_id_q   <= '0;
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cin_q   <= op_cin_d;
      op_last_q  <= op_last_d;
      op_id_q    <= op_id_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_last_q <= res_last_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_valid = res_vld_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_last  = res_last_q;
  assign res_id    = res_id_q;
  assign ops_done  = ops_done_q;
  assign busy      = busy_q;

endmodule
